// File: rtl/ahb_resp_mux_if.sv
// Address-phase select, per-slave response channels and the muxed master-side response.
// The 'slave' modport belongs to the response mux; 'master' is the driving/observing side.
interface ahb_resp_mux_if #(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_SLV-1:0]        hsel_i;
    logic [1:0]                htrans_i;
    logic [NUM_SLV*DATA_W-1:0] hrdata_s_i;
    logic [NUM_SLV-1:0]        hreadyout_s_i;
    logic [NUM_SLV-1:0]        hresp_s_i;
    logic [DATA_W-1:0]         hrdata_o;
    logic                      hready_o;
    logic                      hresp_o;
    logic                      decode_err_o;

    modport slave (
        input  hsel_i, htrans_i, hrdata_s_i, hreadyout_s_i, hresp_s_i,
        output hrdata_o, hready_o, hresp_o, decode_err_o
    );

    modport master (
        output hsel_i, htrans_i, hrdata_s_i, hreadyout_s_i, hresp_s_i,
        input  hrdata_o, hready_o, hresp_o, decode_err_o
    );
endinterface

// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response mux with integrated default slave; data phase is one cycle after
// the address phase, no added latency; stalls (hready_o=0) freeze the registered select.
module ahb_resp_mux #(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_resp_mux_if.slave      bus
);
    localparam int SEL_W = NUM_SLV;

    typedef enum logic [1:0] {
        DP_OKAY = 2'd0,
        DP_SLV  = 2'd1,
        DP_ERR1 = 2'd2,
        DP_ERR2 = 2'd3
    } dp_state_e;

    dp_state_e         dp_state_q, dp_state_d;
    logic [SEL_W-1:0]  dp_sel_q,   dp_sel_d;

    logic [SEL_W-1:0]  hsel_w;
    logic              sel_onehot;
    logic              xfer_req;
    logic [DATA_W-1:0] slv_rdata;
    logic              slv_ready;
    logic              slv_resp;
    logic              hready_w;
    logic              unused_htrans0;

    // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, which respond identically here.
    assign unused_htrans0 = bus.htrans_i[0];

    assign hsel_w     = bus.hsel_i;
    assign xfer_req   = bus.htrans_i[1];
    assign sel_onehot = (hsel_w != '0) && ((hsel_w & (hsel_w - SEL_W'(1))) == '0);

    // AND-OR select keeps unselected (possibly X) channels off the outputs.
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            slv_rdata = slv_rdata | (bus.hrdata_s_i[i*DATA_W +: DATA_W] & {DATA_W{dp_sel_q[i]}});
            slv_ready = slv_ready | (bus.hreadyout_s_i[i] & dp_sel_q[i]);
            slv_resp  = slv_resp  | (bus.hresp_s_i[i]     & dp_sel_q[i]);
        end
    end

    always_comb begin
        hready_w         = 1'b1;
        bus.hrdata_o     = '0;
        bus.hresp_o      = 1'b0;
        bus.decode_err_o = 1'b0;
        case (dp_state_q)
            DP_SLV: begin
                hready_w     = slv_ready;
                bus.hrdata_o = slv_rdata;
                bus.hresp_o  = slv_resp;
            end
            DP_ERR1: begin
                hready_w         = 1'b0;
                bus.hresp_o      = 1'b1;
                bus.decode_err_o = 1'b1;
            end
            DP_ERR2: begin
                hready_w    = 1'b1;
                bus.hresp_o = 1'b1;
            end
            default: begin
                hready_w = 1'b1;
            end
        endcase
        bus.hready_o = hready_w;
    end

    // ERR1 always advances to ERR2; otherwise a new address phase is taken only when ready.
    always_comb begin
        dp_state_d = dp_state_q;
        dp_sel_d   = dp_sel_q;
        if (dp_state_q == DP_ERR1) begin
            dp_state_d = DP_ERR2;
            dp_sel_d   = '0;
        end else if (hready_w) begin
            if (!xfer_req) begin
                dp_state_d = DP_OKAY;
                dp_sel_d   = '0;
            end else if (sel_onehot) begin
                dp_state_d = DP_SLV;
                dp_sel_d   = hsel_w;
            end else begin
                dp_state_d = DP_ERR1;
                dp_sel_d   = '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_state_q <= DP_OKAY;
            dp_sel_q   <= '0;
        end else begin
            dp_state_q <= dp_state_d;
            dp_sel_q   <= dp_sel_d;
        end
    end
endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed cycle-by-cycle vectors for the AHB response mux, plus async-reset and single-slave sequences.
module tb_ahb_resp_mux;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    localparam logic [31:0] D0 = 32'h0A0A_0A0A;
    localparam logic [31:0] D1 = 32'h1B1B_1B1B;
    localparam logic [31:0] D2 = 32'h2C2C_2C2C;
    localparam logic [31:0] D3 = 32'h3D3D_3D3D;
    localparam logic [31:0] DX = 32'hxxxx_xxxx;

    logic clk;
    logic rst_n;

    ahb_resp_mux_if #(.NUM_SLV(4), .DATA_W(32)) bus ();
    ahb_resp_mux_if #(.NUM_SLV(1), .DATA_W(32)) bus1 ();

    ahb_resp_mux #(.NUM_SLV(4), .DATA_W(32)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    ahb_resp_mux #(.NUM_SLV(1), .DATA_W(32)) dut1 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   hsel;
        logic [1:0]   htrans;
        logic [3:0]   rdy;
        logic [3:0]   resp;
        logic [127:0] rdata;
        logic [31:0]  e_rdata;
        logic         e_rdy;
        logic         e_resp;
        logic         e_derr;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input string name, input logic [3:0] hsel, input logic [1:0] htrans,
                                input logic [3:0] rdy, input logic [3:0] resp,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [31:0] er, input logic erdy, input logic eresp,
                                input logic ederr);
        vec_t v;
        v.name    = name;
        v.hsel    = hsel;
        v.htrans  = htrans;
        v.rdy     = rdy;
        v.resp    = resp;
        v.rdata   = {d3, d2, d1, d0};
        v.e_rdata = er;
        v.e_rdy   = erdy;
        v.e_resp  = eresp;
        v.e_derr  = ederr;
        return v;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] ard, input logic ardy, input logic arsp, input logic ade,
                         input logic [31:0] erd, input logic erdy, input logic ersp, input logic ede);
        n_vec++;
        if ({ard, ardy, arsp, ade} !== {erd, erdy, ersp, ede}) begin
            n_miss++;
            $display("FAIL %s: got rdata=%h ready=%b resp=%b derr=%b, expected rdata=%h ready=%b resp=%b derr=%b",
                     name, ard, ardy, arsp, ade, erd, erdy, ersp, ede);
        end
    endtask

    task automatic drive(input logic [3:0] hsel, input logic [1:0] htrans, input logic [3:0] rdy,
                         input logic [3:0] resp, input logic [127:0] rdata);
        bus.hsel_i        = hsel;
        bus.htrans_i      = htrans;
        bus.hreadyout_s_i = rdy;
        bus.hresp_s_i     = resp;
        bus.hrdata_s_i    = rdata;
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back(mk("idle_after_rst", 4'b0000, IDLE, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 1, 0, 0));
        vt.push_back(mk("addr_s1",        4'b0010, NSEQ, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 1, 0, 0));
        vt.push_back(mk("stall_1",        4'b1000, NSEQ, 4'b1101, 4'b0000, D0, 32'h5555_0001, D2, D3, 32'h5555_0001, 0, 0, 0));
        vt.push_back(mk("stall_2",        4'b1000, NSEQ, 4'b1101, 4'b0000, D0, 32'h5555_0001, D2, D3, 32'h5555_0001, 0, 0, 0));
        vt.push_back(mk("stall_done",     4'b0000, IDLE, 4'b1111, 4'b0000, D0, 32'hDEAD_BEEF, D2, D3, 32'hDEAD_BEEF, 1, 0, 0));
        vt.push_back(mk("unmapped_addr",  4'b0000, NSEQ, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 1, 0, 0));
        vt.push_back(mk("unmapped_err1",  4'b0000, IDLE, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 0, 1, 1));
        vt.push_back(mk("unmapped_err2",  4'b0000, IDLE, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 1, 1, 0));
        vt.push_back(mk("multihot_addr",  4'b0101, NSEQ, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 1, 0, 0));
        vt.push_back(mk("multihot_err1",  4'b0001, NSEQ, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 0, 1, 1));
        vt.push_back(mk("multihot_err2",  4'b0001, SEQ,  4'b1111, 4'b0000, 32'h1, D1, D2, D3, 32'h0, 1, 1, 0));
        vt.push_back(mk("b2b_s0",         4'b1000, SEQ,  4'b1111, 4'b0000, 32'h1, D1, D2, 32'h3, 32'h1, 1, 0, 0));
        vt.push_back(mk("b2b_s3",         4'b0001, IDLE, 4'b1111, 4'b0000, 32'h1, D1, D2, 32'h3, 32'h3, 1, 0, 0));
        vt.push_back(mk("idle_nosel",     4'b0000, IDLE, 4'b1111, 4'b0000, 32'hFFFF_FFFF, D1, D2, D3, 32'h0, 1, 0, 0));
        vt.push_back(mk("addr_s2",        4'b0100, NSEQ, 4'b1111, 4'b0000, D0, D1, D2, D3, 32'h0, 1, 0, 0));
        vt.push_back(mk("slv_err1",       4'b0000, IDLE, 4'b1011, 4'b0100, DX, DX, D2, D3, D2, 0, 1, 0));
        vt.push_back(mk("slv_err2",       4'b0000, IDLE, 4'b1111, 4'b0100, D0, D1, D2, D3, D2, 1, 1, 0));
        vt.push_back(mk("okay_x_inputs",  4'b0000, IDLE, 4'bxxxx, 4'bxxxx, DX, DX, DX, DX, 32'h0, 1, 0, 0));

        rst_n = 1'b0;
        drive(4'b0000, IDLE, 4'b1111, 4'b0000, {D3, D2, D1, D0});
        bus1.hsel_i        = 1'b0;
        bus1.htrans_i      = IDLE;
        bus1.hreadyout_s_i = 1'b1;
        bus1.hresp_s_i     = 1'b0;
        bus1.hrdata_s_i    = 32'h0;

        #3;
        check("reset_4slv", bus.hrdata_o, bus.hready_o, bus.hresp_o, bus.decode_err_o, 32'h0, 1, 0, 0);
        check("reset_1slv", bus1.hrdata_o, bus1.hready_o, bus1.hresp_o, bus1.decode_err_o, 32'h0, 1, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].hsel, vt[i].htrans, vt[i].rdy, vt[i].resp, vt[i].rdata);
            #1;
            check(vt[i].name, bus.hrdata_o, bus.hready_o, bus.hresp_o, bus.decode_err_o,
                  vt[i].e_rdata, vt[i].e_rdy, vt[i].e_resp, vt[i].e_derr);
            @(negedge clk);
        end

        // Reset pulse during the first ERROR cycle must clear outputs without a clock edge.
        drive(4'b0000, NSEQ, 4'b1111, 4'b0000, {D3, D2, D1, D0});
        @(negedge clk);
        drive(4'b0000, IDLE, 4'b1111, 4'b0000, {D3, D2, D1, D0});
        #1;
        check("rst_pre_err1", bus.hrdata_o, bus.hready_o, bus.hresp_o, bus.decode_err_o, 32'h0, 0, 1, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async", bus.hrdata_o, bus.hready_o, bus.hresp_o, bus.decode_err_o, 32'h0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0100, NSEQ, 4'b1111, 4'b0000, {D3, 32'h0C0F_FEE0, D1, D0});
        @(negedge clk);
        drive(4'b0000, IDLE, 4'b1111, 4'b0000, {D3, 32'h0C0F_FEE0, D1, D0});
        #1;
        check("post_rst_s2", bus.hrdata_o, bus.hready_o, bus.hresp_o, bus.decode_err_o, 32'h0C0F_FEE0, 1, 0, 0);

        // Single-slave instance: zero select on NONSEQ still reaches the default slave.
        @(negedge clk);
        bus1.hsel_i   = 1'b0;
        bus1.htrans_i = NSEQ;
        @(negedge clk);
        bus1.hsel_i     = 1'b1;
        bus1.htrans_i   = NSEQ;
        bus1.hrdata_s_i = 32'h0000_00AB;
        #1;
        check("n1_err1", bus1.hrdata_o, bus1.hready_o, bus1.hresp_o, bus1.decode_err_o, 32'h0, 0, 1, 1);
        @(negedge clk);
        #1;
        check("n1_err2", bus1.hrdata_o, bus1.hready_o, bus1.hresp_o, bus1.decode_err_o, 32'h0, 1, 1, 0);
        @(negedge clk);
        bus1.hsel_i   = 1'b0;
        bus1.htrans_i = IDLE;
        #1;
        check("n1_slv0", bus1.hrdata_o, bus1.hready_o, bus1.hresp_o, bus1.decode_err_o, 32'h0000_00AB, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- Parametrised slave-to-master response multiplexer for the generated AHB interconnect; successor to the combinational one-hot payload mux.
- Registers the address-phase slave select and holds it for the whole data phase, including wait states, so HRDATA/HREADY/HRESP follow AHB pipelining.
- Contains an integrated default slave: a two-cycle ERROR for unmapped or multi-hot transfers, zero-wait OKAY for IDLE/BUSY.
- Sits between the address decoder and the master port, one instance per master.

Parameters:
- NUM_SLV, 4, number of slave channels (1..32).
- DATA_W, 32, HRDATA width (32, 64 or 128).
- SEL_W, NUM_SLV, width of the one-hot select. Derived; not to be overridden.

Ports:
- HCLK  input  1  bus clock; all state updates on the rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- hsel_i  input  NUM_SLV  address-phase one-hot slave select from the decoder.
- htrans_i  input  2  address-phase HTRANS: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hrdata_s_i  input  NUM_SLV*DATA_W  packed slave read data; slave i at bits [i*DATA_W +: DATA_W].
- hreadyout_s_i  input  NUM_SLV  per-slave HREADYOUT.
- hresp_s_i  input  NUM_SLV  per-slave HRESP (1 = ERROR).
- hrdata_o  output  DATA_W  muxed read data to the master.
- hready_o  output  1  muxed HREADY to the master. Also fanned back to all slaves as HREADY.
- hresp_o  output  1  muxed HRESP to the master.
- decode_err_o  output  1  one-cycle pulse when a default-slave ERROR starts.

Behaviour:
- Reset (async, HRESETn=0): dp_sel=0, dp_state=DP_OKAY, hready_o=1, hresp_o=0, hrdata_o=0, decode_err_o=0.
- Address-phase sampling happens only on edges where hready_o=1. When hready_o=0 every registered value holds.
- Sample classification:
  - Valid transfer: htrans_i[1]=1 and hsel_i has exactly one bit set. dp_sel<=hsel_i, dp_state<=DP_SLV.
  - Unmapped/illegal: htrans_i[1]=1 and hsel_i is zero or multi-hot. dp_sel<=0, dp_state<=DP_ERR1, decode_err_o pulses high for that next cycle.
  - IDLE/BUSY (htrans_i[1]=0), any hsel_i: dp_sel<=0, dp_state<=DP_OKAY.
- Output function, combinational from the registered state:
  - DP_SLV: hrdata_o=hrdata_s_i[k], hready_o=hreadyout_s_i[k], hresp_o=hresp_s_i[k], where k is the set bit of dp_sel.
  - DP_OKAY: hrdata_o=0, hready_o=1, hresp_o=0.
  - DP_ERR1: hready_o=0, hresp_o=1, hrdata_o=0. Unconditional next state is DP_ERR2, with no address sampling.
  - DP_ERR2: hready_o=1, hresp_o=1, hrdata_o=0. Normal address sampling applies on this edge.
- Latency: data phase is one cycle after the address phase; the mux adds no cycles beyond the slave's own wait states.
- Slave ERROR pass-through: a slave's two-cycle ERROR is forwarded as-is; the mux does not re-time it.
- Back-to-back transfers: a new address phase sampled in the last data-phase cycle of the previous transfer (hready_o=1) switches dp_sel on the same edge. There is no bubble.
- NUM_SLV=1: hsel_i is 1 bit. Zero hsel with NONSEQ/SEQ still hits the default slave.
- Reset asserted mid-transfer or mid-ERROR: outputs return to reset values immediately, without waiting for the clock.
- Unused slave inputs with dp_sel=0 must not affect any output. No X-propagation from unselected channels.

Test Plan:
- Reset, then NONSEQ with hsel_i=4'b0010; slave1 has hreadyout=0 for 2 cycles then hrdata=32'hDEAD_BEEF with ready=1 -> hready_o low 2 cycles; in the 3rd data-phase cycle hready_o=1 and hrdata_o=32'hDEAD_BEEF. During the stall, hsel_i changed to 4'b1000 must not switch channels.
- NONSEQ with hsel_i=4'b0000 -> next cycle hready_o=0, hresp_o=1, decode_err_o=1; following cycle hready_o=1, hresp_o=1, decode_err_o=0; then OKAY.
- NONSEQ with hsel_i=4'b0101 (multi-hot) -> same two-cycle ERROR as unmapped; no slave data reaches hrdata_o.
- Back-to-back SEQ to slave0 (data 32'h1) then slave3 (data 32'h3), both zero-wait -> hrdata_o is 32'h1 then 32'h3 in consecutive cycles, hready_o=1 throughout.
- IDLE with hsel_i=4'b0001 -> next cycle hready_o=1, hresp_o=0, hrdata_o=0, slave0 not selected.
- HRESETn pulsed low during DP_ERR1 -> hready_o=1 and hresp_o=0 immediately; after release the next NONSEQ to slave2 is served normally.
